// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared types for the control-unit operation sequencer.
//   cu_op_e        : {Ctrl1,Ctrl0} opcode of the 4-bit control unit
//   cu_cmd_t       : queued command (opcode plus two 4-bit operands)
//   cu_rsp_t       : captured result (opcode, {ResH,ResL}, {Zero,Overflow,Cout})
//   cu_seq_state_e : sequencer FSM state, also exported on the debug port
// -----------------------------------------------------------------------------
package cu_pkg;

  typedef enum logic [1:0] {
    CU_ADD = 2'b00,
    CU_SUB = 2'b01,
    CU_MUL = 2'b10,
    CU_AND = 2'b11
  } cu_op_e;

  typedef struct packed {
    cu_op_e     op;
    logic [3:0] a;
    logic [3:0] b;
  } cu_cmd_t;

  typedef struct packed {
    cu_op_e     op;
    logic [7:0] data;
    logic [2:0] flags;
  } cu_rsp_t;

  typedef enum logic [1:0] {
    SEQ_IDLE        = 2'b00,
    SEQ_SETTLE_WAIT = 2'b01,
    SEQ_HOLD        = 2'b10
  } cu_seq_state_e;

endpackage

// File: rtl/cu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// cu_cmd_fifo
// Synchronous command FIFO, DEPTH entries (power of two, >= 2).
// Not fall-through: an entry written on an edge is readable from the next
// cycle, because empty/full derive only from the registered pointers.
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push, din   : write request and payload (ignored when full)
//   pop,  dout  : read request (ignored when empty) and head entry
//   full, empty : occupancy status
// -----------------------------------------------------------------------------
module cu_cmd_fifo
  import cu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  cu_cmd_t din,
  input  logic    pop,
  output cu_cmd_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  cu_cmd_t       mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible through non-empty slots.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cu_op_sequencer.sv
// -----------------------------------------------------------------------------
// cu_op_sequencer
// Issuing side of the 4-bit control unit. Commands are queued in a FIFO, driven
// to the control unit from registers, results sampled SETTLE cycles later and
// returned in command order on a response channel.
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid && ready. The producer keeps valid and payload stable until that
// edge; ready never depends combinationally on valid. cmd_ready is !full only.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : command input channel
//   cu_ctrl1/cu_ctrl0/cu_a/cu_b  : registered drive to the control unit
//   cu_resl/cu_resh/cu_zero/cu_overflow/cu_cout : control unit results
//   rsp_valid/rsp_ready/rsp_op/rsp_data/rsp_flags : response channel,
//                                  rsp_data={ResH,ResL}, rsp_flags={Zero,Overflow,Cout}
//   busy                         : FIFO non-empty or FSM not idle
//   dbg_state                    : current FSM state
//   stat_ops/stat_ovf            : saturating hand-off counters, present only
//                                  when CU_SEQ_STATS_EN is defined
// -----------------------------------------------------------------------------
module cu_op_sequencer
  import cu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [3:0]    cmd_a,
  input  logic [3:0]    cmd_b,
  output logic          cu_ctrl1,
  output logic          cu_ctrl0,
  output logic [3:0]    cu_a,
  output logic [3:0]    cu_b,
  input  logic [3:0]    cu_resl,
  input  logic [3:0]    cu_resh,
  input  logic          cu_zero,
  input  logic          cu_overflow,
  input  logic          cu_cout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [1:0]    rsp_op,
  output logic [7:0]    rsp_data,
  output logic [2:0]    rsp_flags,
  output logic          busy,
  output cu_seq_state_e dbg_state
`ifdef CU_SEQ_STATS_EN
  ,
  output logic [15:0]   stat_ops,
  output logic [15:0]   stat_ovf
`endif
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  cu_seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cu_cmd_t       cu_cmd_q, cu_cmd_d;
  cu_rsp_t       rsp_q, rsp_d;
  logic          rsp_valid_q, rsp_valid_d;

  cu_cmd_t       cmd_in, fifo_dout;
  logic          fifo_full, fifo_empty, fifo_pop, handshake;

  assign cmd_in    = '{op: cu_op_e'(cmd_op), a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full;
  assign handshake = rsp_valid_q && rsp_ready;

  cu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   (cmd_in),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cu_cmd_d    = cu_cmd_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    fifo_pop    = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cu_cmd_d = fifo_dout;
          cnt_d    = CW'(SETTLE - 1);
          state_d  = SEQ_SETTLE_WAIT;
        end
      end
      SEQ_SETTLE_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rsp_d.op    = cu_cmd_q.op;
          rsp_d.data  = {cu_resh, cu_resl};
          rsp_d.flags = {cu_zero, cu_overflow, cu_cout};
          rsp_valid_d = 1'b1;
          state_d     = SEQ_HOLD;
        end
      end
      SEQ_HOLD: begin
        if (handshake) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            // Issue the next command on the same edge the result leaves.
            fifo_pop = 1'b1;
            cu_cmd_d = fifo_dout;
            cnt_d    = CW'(SETTLE - 1);
            state_d  = SEQ_SETTLE_WAIT;
          end else begin
            state_d = SEQ_IDLE;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEQ_IDLE;
      cnt_q       <= '0;
      cu_cmd_q    <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cu_cmd_q    <= cu_cmd_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign {cu_ctrl1, cu_ctrl0} = cu_cmd_q.op;
  assign cu_a      = cu_cmd_q.a;
  assign cu_b      = cu_cmd_q.b;
  assign rsp_valid = rsp_valid_q;
  assign rsp_op    = rsp_q.op;
  assign rsp_data  = rsp_q.data;
  assign rsp_flags = rsp_q.flags;
  assign busy      = !fifo_empty || (state_q != SEQ_IDLE);
  assign dbg_state = state_q;

`ifdef CU_SEQ_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_ovf_q, stat_ovf_d;

  always_comb begin
    stat_ops_d = stat_ops_q;
    stat_ovf_d = stat_ovf_q;
    if (handshake) begin
      if (stat_ops_q != 16'hFFFF) stat_ops_d = stat_ops_q + 16'd1;
      if (rsp_q.flags[1] && (stat_ovf_q != 16'hFFFF)) stat_ovf_d = stat_ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_ovf_q <= stat_ovf_d;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_cu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cu_op_sequencer
// Bench for cu_op_sequencer (DEPTH=4, SETTLE=1) with a behavioural 4-bit
// control unit attached to the cu_* ports. Inputs are driven and outputs
// sampled 1 time unit after each rising edge. Define CU_SEQ_STATS_EN to
// include the statistics counters.
// -----------------------------------------------------------------------------
module tb_cu_op_sequencer;
  import cu_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [3:0]    cmd_a, cmd_b;
  logic          cu_ctrl1, cu_ctrl0;
  logic [3:0]    cu_a, cu_b;
  logic [3:0]    cu_resl, cu_resh;
  logic          cu_zero, cu_overflow, cu_cout;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_op;
  logic [7:0]    rsp_data;
  logic [2:0]    rsp_flags;
  logic          busy;
  cu_seq_state_e dbg_state;
`ifdef CU_SEQ_STATS_EN
  logic [15:0]   stat_ops, stat_ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  cu_op_sequencer #(.DEPTH(4), .SETTLE(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cu_ctrl1    (cu_ctrl1),
    .cu_ctrl0    (cu_ctrl0),
    .cu_a        (cu_a),
    .cu_b        (cu_b),
    .cu_resl     (cu_resl),
    .cu_resh     (cu_resh),
    .cu_zero     (cu_zero),
    .cu_overflow (cu_overflow),
    .cu_cout     (cu_cout),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_op      (rsp_op),
    .rsp_data    (rsp_data),
    .rsp_flags   (rsp_flags),
    .busy        (busy),
    .dbg_state   (dbg_state)
`ifdef CU_SEQ_STATS_EN
    ,
    .stat_ops    (stat_ops),
    .stat_ovf    (stat_ovf)
`endif
  );

  // ---------------- control unit model ----------------
  // ADD/SUB: 4-bit result sign-extended into ResH; MUL: signed 8-bit product;
  // AND: zero-extended. Cout is the unsigned carry of ADD only.
  always_comb begin
    logic [4:0] sum5;
    logic [3:0] r4;
    logic [7:0] prod;
    sum5 = 5'd0;
    r4 = 4'd0;
    prod = 8'd0;
    cu_resl = 4'd0;
    cu_resh = 4'd0;
    cu_overflow = 1'b0;
    cu_cout = 1'b0;
    case ({cu_ctrl1, cu_ctrl0})
      2'b00: begin
        sum5 = {1'b0, cu_a} + {1'b0, cu_b};
        r4 = sum5[3:0];
        cu_resl = r4;
        cu_resh = {4{r4[3]}};
        cu_overflow = (cu_a[3] == cu_b[3]) && (r4[3] != cu_a[3]);
        cu_cout = sum5[4];
      end
      2'b01: begin
        r4 = cu_a - cu_b;
        cu_resl = r4;
        cu_resh = {4{r4[3]}};
        cu_overflow = (cu_a[3] != cu_b[3]) && (r4[3] != cu_a[3]);
      end
      2'b10: begin
        prod = 8'($signed({{4{cu_a[3]}}, cu_a}) * $signed({{4{cu_b[3]}}, cu_b}));
        {cu_resh, cu_resl} = prod;
      end
      default: begin
        cu_resl = cu_a & cu_b;
      end
    endcase
    cu_zero = ({cu_resh, cu_resl} == 8'h00);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command from idle, waits (bounded) for the response, returns
  // what was observed and the number of edges after the accept edge, then
  // consumes the response.
  task automatic do_single(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           output int lat, output logic [7:0] d, output logic [2:0] f,
                           output logic [1:0] o);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    d = rsp_data;
    f = rsp_flags;
    o = rsp_op;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit saw_valid;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_a = 4'd0;
    cmd_b = 4'd0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: cmd_ready=%b busy=%b rsp_valid=%b, required 1 0 0",
               cmd_ready, busy, rsp_valid);
    end
    checks++;
    if ({cu_ctrl1, cu_ctrl0, cu_a, cu_b} !== 10'd0) begin
      errors++;
      $display("FAIL reset_cu: ctrl=%b%b a=%h b=%h, required all 0", cu_ctrl1, cu_ctrl0, cu_a, cu_b);
    end
    checks++;
    if ({rsp_op, rsp_data, rsp_flags} !== 13'd0) begin
      errors++;
      $display("FAIL reset_rsp: op=%b data=%h flags=%b, required all 0", rsp_op, rsp_data, rsp_flags);
    end
    // Two commands queued, first one in SETTLE_WAIT when reset hits.
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_a = 4'd1;
    cmd_b = 4'd1;
    tick();
    cmd_a = 4'd2;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (dbg_state !== SEQ_SETTLE_WAIT) begin
      errors++;
      $display("FAIL midop_state: state=%0d, required %0d", dbg_state, SEQ_SETTLE_WAIT);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset: busy=%b rsp_valid=%b cmd_ready=%b, required 0 0 1",
               busy, rsp_valid, cmd_ready);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid || busy) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_dropped: activity after reset=%b, required 0", saw_valid);
    end
  endtask

  task automatic test_add();
    int lat;
    logic [7:0] d;
    logic [2:0] f;
    logic [1:0] o;
    do_single(2'b00, 4'd3, 4'd4, lat, d, f, o);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL add_latency: edges=%0d, required 2", lat);
    end
    checks++;
    if (d !== 8'h07 || f !== 3'b000 || o !== 2'b00) begin
      errors++;
      $display("FAIL add_3_4: data=%h flags=%b op=%b, required 07 000 00", d, f, o);
    end
    do_single(2'b00, 4'd7, 4'd1, lat, d, f, o);
    checks++;
    if (d !== 8'hF8 || f !== 3'b010) begin
      errors++;
      $display("FAIL add_7_1: data=%h flags=%b, required f8 010", d, f);
    end
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_idle: busy=%b rsp_valid=%b, required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_sub();
    int lat;
    logic [7:0] d;
    logic [2:0] f;
    logic [1:0] o;
    do_single(2'b01, 4'd2, 4'd5, lat, d, f, o);
    checks++;
    if (d !== 8'hFD || f !== 3'b000 || o !== 2'b01) begin
      errors++;
      $display("FAIL sub_2_5: data=%h flags=%b op=%b, required fd 000 01", d, f, o);
    end
    do_single(2'b01, 4'd5, 4'd5, lat, d, f, o);
    checks++;
    if (d !== 8'h00 || f[2] !== 1'b1 || f[0] !== 1'b0) begin
      errors++;
      $display("FAIL sub_5_5: data=%h flags=%b, required 00 1x0", d, f);
    end
  endtask

  task automatic test_mul_and();
    int lat;
    logic [7:0] d;
    logic [2:0] f;
    logic [1:0] o;
    do_single(2'b10, 4'b1101, 4'd5, lat, d, f, o);
    checks++;
    if (d !== 8'hF1 || f !== 3'b000 || o !== 2'b10) begin
      errors++;
      $display("FAIL mul_m3_5: data=%h flags=%b op=%b, required f1 000 10", d, f, o);
    end
    do_single(2'b11, 4'b1100, 4'b1010, lat, d, f, o);
    checks++;
    if (d !== 8'h08 || o !== 2'b11) begin
      errors++;
      $display("FAIL and_c_a: data=%h op=%b, required 08 11", d, o);
    end
    checks++;
    if ({cu_ctrl1, cu_ctrl0} !== 2'b11 || cu_a !== 4'b1100 || cu_b !== 4'b1010) begin
      errors++;
      $display("FAIL cu_hold_idle: ctrl=%b%b a=%b b=%b, required 11 1100 1010",
               cu_ctrl1, cu_ctrl0, cu_a, cu_b);
    end
  endtask

  task automatic test_back_to_back();
    int accepted;
    int last;
    int n;
    logic last_ready;
    logic [7:0] exp;
    rsp_ready = 1'b0;
    accepted = 0;
    last_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 2'b00;
      cmd_a = 4'(i);
      cmd_b = 4'd1;
      last_ready = cmd_ready;
      if (cmd_ready) begin
        accepted++;
        exp_q.push_back(8'(i + 1));
      end
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (accepted !== 5 || last_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_capacity: accepted=%0d ready_on_6th=%b, required 5 0", accepted, last_ready);
    end
    rsp_ready = 1'b1;
    last = -1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (rsp_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        checks++;
        if (rsp_data !== exp) begin
          errors++;
          $display("FAIL bp_order: data=%h, required %h", rsp_data, exp);
        end
        if (last >= 0) begin
          checks++;
          if (c - last !== 2) begin
            errors++;
            $display("FAIL bp_rate: spacing=%0d cycles, required 2", c - last);
          end
        end
        last = c;
        n++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    checks++;
    if (n !== 5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: responses=%0d busy=%b, required 5 0", n, busy);
    end
    exp_q.delete();
  endtask

`ifdef CU_SEQ_STATS_EN
  task automatic test_stats();
    int lat;
    logic [7:0] d;
    logic [2:0] f;
    logic [1:0] o;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_single(2'b00, 4'd3, 4'd4, lat, d, f, o);
    do_single(2'b00, 4'd7, 4'd1, lat, d, f, o);
    do_single(2'b00, 4'd1, 4'd1, lat, d, f, o);
    checks++;
    if (stat_ops !== 16'd3 || stat_ovf !== 16'd1) begin
      errors++;
      $display("FAIL stats_count: ops=%0d ovf=%0d, required 3 1", stat_ops, stat_ovf);
    end
    dut.stat_ops_q = 16'hFFFE;
    dut.stat_ovf_q = 16'hFFFE;
    for (int i = 0; i < 3; i++) do_single(2'b00, 4'd7, 4'd1, lat, d, f, o);
    checks++;
    if (stat_ops !== 16'hFFFF || stat_ovf !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_saturate: ops=%h ovf=%h, required ffff ffff", stat_ops, stat_ovf);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul_and();
    test_back_to_back();
`ifdef CU_SEQ_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
